// File: rtl/fifo_256_gather_pkg.sv
// Shared constants and helpers for the narrow-in / wide-out gather FIFO.
package fifo_256_pkg;

    localparam int WORD_W = 16;
    localparam int LANES  = 16;

    // Requested burst size in words; an encoding of 0 stands for a full 16-word burst.
    function automatic logic [4:0] size_decode(input logic [3:0] size);
        return (size == 4'd0) ? 5'd16 : {1'b0, size};
    endfunction

endpackage

// File: rtl/fifo_256_gather_word_gather_16.sv
// Packs up to 16 consecutive stored words, starting at rd_ptr and wrapping
// modulo DEPTH, into one LSB-first wide bus; lanes at or beyond n read as zero.
module word_gather_16
    import fifo_256_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic [WORD_W-1:0]        mem [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] rd_ptr,
    input  logic [4:0]               n,
    output logic [LANES*WORD_W-1:0]  burst
);

    localparam int AW = $clog2(DEPTH);

    // Lane k takes the word k places after rd_ptr; the pointer-width add wraps for free.
    always_comb begin
        burst = '0;
        for (int k = 0; k < LANES; k++) begin
            if (5'(k) < n) begin
                burst[WORD_W*k +: WORD_W] = mem[rd_ptr + AW'(k)];
            end
        end
    end

endmodule

// File: rtl/fifo_256_gather.sv
// Gather FIFO: one 16-bit word written per cycle, bursts of 1..16 words read
// out in a single cycle on a 256-bit bus, one cycle after the read is accepted.
module fifo_256_gather
    import fifo_256_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       reset_p,
    input  logic [WORD_W-1:0]          data_i,
    input  logic                       data_we,
    output logic                       full,
    input  logic [3:0]                 size_i,
    input  logic                       data_rd,
    output logic                       rd_ready,
    output logic [LANES*WORD_W-1:0]    data_o,
    output logic                       data_o_valid,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     word_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WORD_W-1:0]       mem [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [4:0]              n;
    logic                    wr_acc;
    logic                    rd_acc;
    logic [LANES*WORD_W-1:0] burst;

    // Status flags come from the registered count, so a word written this
    // cycle only becomes visible to full/rd_ready on the next cycle.
    assign n        = size_decode(size_i);
    assign full     = (word_cnt == CW'(DEPTH));
    assign empty    = (word_cnt == '0);
    assign rd_ready = (word_cnt >= CW'(n));
    assign wr_acc   = data_we & ~full;
    assign rd_acc   = data_rd & rd_ready;

    word_gather_16 #(
        .DEPTH (DEPTH)
    ) u_gather (
        .mem    (mem),
        .rd_ptr (rd_ptr),
        .n      (n),
        .burst  (burst)
    );

    // Storage: accepted words land at wr_ptr; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping; a read and a write may complete together.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            word_cnt <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(n);
            end
            word_cnt <= word_cnt + CW'(wr_acc) - (rd_acc ? CW'(n) : CW'(0));
        end
    end

    // Output register: capture the gathered burst on an accepted read, else hold
    // the bus and drop the valid pulse. Reset clears both, dropping any same-cycle read.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            data_o       <= '0;
            data_o_valid <= 1'b0;
        end else begin
            data_o_valid <= rd_acc;
            if (rd_acc) begin
                data_o <= burst;
            end
        end
    end

endmodule

// File: doc/fifo_256_gather.md
Name: fifo_256_gather

Overview:
- Mirror-direction companion to the credit-return wide-write FIFO.
- Accepts one 16-bit word per cycle on the narrow side.
- Delivers bursts of 1 to 16 words, packed LSB-first, on a 256-bit read bus in a single read cycle.
- Used where a narrow producer feeds a wide consumer that drains variable-size chunks, e.g. for credit-return packing.

Parameters:
- DEPTH, 64, storage depth in 16-bit words; power of two, multiple of 16, minimum 16.

Ports:
- clk  in  1  clock; all logic on rising edge
- reset_p  in  1  synchronous reset, active-high (1 = reset)
- data_i  in  16  write word
- data_we  in  1  1 = write data_i this cycle (ignored when full=1)
- full  out  1  1 = word_cnt == DEPTH
- size_i  in  4  requested read size in words; 0 means 16
- data_rd  in  1  1 = read size_i words (ignored when rd_ready=0)
- rd_ready  out  1  1 = word_cnt >= decoded size_i (combinational from size_i and registered word_cnt)
- data_o  out  256  read burst; word k at [16*k+:16], unused upper words = 0
- data_o_valid  out  1  1-cycle pulse, data_o valid
- empty  out  1  1 = word_cnt == 0
- word_cnt  out  $clog2(DEPTH)+1  registered count of stored words

Behaviour:
- Reset (synchronous, reset_p=1 at the clock edge):
  - wr_ptr, rd_ptr, word_cnt = 0; data_o = 0; data_o_valid = 0.
  - Hence empty=1, full=0, rd_ready=0.
  - Reset mid-burst discards all stored words; a read accepted in the same cycle as reset is dropped, and data_o_valid stays 0.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - Storage is a word-addressed array of DEPTH x 16.
- Write accept: wr_acc = data_we & ~full.
  - On acceptance, mem[wr_ptr] <= data_i and wr_ptr += 1.
  - A write while full is dropped with no state change.
- Size decode: n = (size_i==0) ? 16 : size_i, 5 bits.
- Read accept: rd_acc = data_rd & rd_ready.
  - On acceptance, data_o[16*k+:16] <= mem[(rd_ptr+k) mod DEPTH] for k<n, else 0; data_o_valid <= 1; rd_ptr += n.
  - Otherwise data_o holds its value and data_o_valid <= 0.
- Read latency: 1 cycle from accepted data_rd to data_o_valid.
- Partial reads never occur. data_rd with rd_ready=0 is ignored, with no pointer change and no valid.
- Wrap: a burst may straddle the DEPTH boundary, e.g. rd_ptr=60, n=8 reads words 60..63, 0..3.
- Simultaneous write and read: word_cnt <= word_cnt + wr_acc - (rd_acc ? n : 0).
  - full and rd_ready use the registered word_cnt, so a word written in cycle N is first readable in cycle N+1.
  - A read in the same cycle as a write while full=1 does not admit that write; the write is still dropped.
- word_cnt arithmetic is $clog2(DEPTH)+1 bits and never exceeds DEPTH or goes below 0 by construction.
- State machine: none beyond the pointer/count registers. A debug-free flat datapath is required.

Decomposition:
- Package fifo_256_pkg:
  - WORD_W=16, LANES=16.
  - Function size_decode(logic [3:0]) returning 5-bit word count (0->16).
- Sub-module word_gather_16 (combinational):
  - Inputs: the memory array view, rd_ptr and n.
  - Outputs: the 256-bit packed, zero-masked burst.
  - Isolates the modulo-DEPTH lane indexing from the pointer/count control.

Test Plan:
1. Reset, then write words 0x0001..0x0010 (16 cycles), then data_rd with size_i=0. Required: rd_ready=1 at the read cycle; next cycle data_o_valid=1, data_o word k = k+1 for k=0..15; afterwards word_cnt=0 and empty=1.
2. Write 3 words 0xA0..0xA2, then data_rd with size_i=4. Required: rd_ready=0 and no valid pulse. Write 0xA3, then data_rd with size_i=4. Required: data_o = {192'h0, A3,A2,A1,A0 as words 3..0}.
3. Fill to DEPTH=64. Required: full=1. A further write of 0xDEAD is dropped and word_cnt stays 64. Then read size_i=5 with a simultaneous write of 0xBEEF. Required: the write is dropped and word_cnt=59.
4. Wrap case: advance rd_ptr/wr_ptr to 60 via write/read of 60 words, then write 0x100..0x107 and read size_i=8. Required: data_o words 0..7 = 0x100..0x107, and data_o_valid asserted exactly 1 cycle after the read.
5. Concurrent streaming: word_cnt=10, then every cycle write 1 word and read size_i=1 for 20 cycles. Required: word_cnt stays 10, data is in order, and there are 20 valid pulses.
6. Assert reset_p for one cycle with word_cnt=30 and a read of size_i=2 accepted in the same cycle. Required: next cycle data_o_valid=0, data_o=0, word_cnt=0, empty=1.
